// File: rtl/pixel_write_arbiter.sv
// ============================================================================
// Module   : pixel_write_arbiter
// Brief    : Arbitrates painter/overlay pixel writes into one registered
//            graphic-manager write port, with an optional full-screen clear.
//            Macro PIXEL_WRITE_ARBITER_CLEAR_EN enables the clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_write_arbiter #(
    parameter int COL_NUM      = 320,
    parameter int ROW_NUM      = 240,
    parameter int STARVE_LIMIT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       initialized,
    input  logic       p_valid,
    input  logic       p_lock,
    input  logic [8:0] p_col,
    input  logic [7:0] p_row,
    input  logic       p_color,
    output logic       p_ready,
    input  logic       o_valid,
    input  logic       o_lock,
    input  logic [8:0] o_col,
    input  logic [7:0] o_row,
    input  logic       o_color,
    output logic       o_ready,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       clear_done,
    input  logic       gm_ready,
    output logic       gm_write,
    output logic [8:0] gm_col,
    output logic [7:0] gm_row,
    output logic       gm_color
);

    localparam int                CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        SERVE_P   = 3'd2,
        SERVE_O   = 3'd3,
        CLEAR     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             gm_write_q;
    logic [8:0]       gm_col_q;
    logic [7:0]       gm_row_q;
    logic             gm_color_q;

    logic             w_stage_free;
    logic             w_o_grant;
    logic             w_beat_load;
    logic [8:0]       w_beat_col;
    logic [7:0]       w_beat_row;
    logic             w_beat_color;

    logic             w_clear_pend;
    logic             w_clr_acc;
    logic             w_clr_last;
    logic [8:0]       w_clr_col;
    logic [7:0]       w_clr_row;

    assign w_stage_free = !gm_write_q || gm_ready;
    assign p_ready      = (state_q == SERVE_P) && p_valid && w_stage_free;
    assign o_ready      = (state_q == SERVE_O) && o_valid && w_stage_free;

    // Overlay wins in IDLE only when the painter is absent or has starved it.
    assign w_o_grant = (state_q == IDLE) && !w_clear_pend && o_valid &&
                       (!p_valid || (starve_q == C_STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!o_valid || w_o_grant) begin
            starve_d = '0;
        end else if (p_ready && (starve_q != C_STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (initialized) state_d = IDLE;
            IDLE: begin
                if (w_clear_pend)   state_d = CLEAR;
                else if (w_o_grant) state_d = SERVE_O;
                else if (p_valid)   state_d = SERVE_P;
            end
            // Preemption is only evaluated once the painter drops its lock.
            SERVE_P: if (!p_lock && (!p_ready || (o_valid && (starve_d == C_STARVE_MAX))))
                         state_d = IDLE;
            SERVE_O: if (!o_lock && !o_ready) state_d = IDLE;
            CLEAR:   if (w_clr_acc && w_clr_last) state_d = IDLE;
            default: state_d = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_INIT;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign w_beat_load = p_ready || o_ready || w_clr_acc;

    always_comb begin
        w_beat_col   = w_clr_col;
        w_beat_row   = w_clr_row;
        w_beat_color = 1'b0;
        if (p_ready) begin
            w_beat_col   = p_col;
            w_beat_row   = p_row;
            w_beat_color = p_color;
        end else if (o_ready) begin
            w_beat_col   = o_col;
            w_beat_row   = o_row;
            w_beat_color = o_color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gm_write_q <= 1'b0;
            gm_col_q   <= '0;
            gm_row_q   <= '0;
            gm_color_q <= 1'b0;
        end else if (w_beat_load) begin
            gm_write_q <= 1'b1;
            gm_col_q   <= w_beat_col;
            gm_row_q   <= w_beat_row;
            gm_color_q <= w_beat_color;
        end else if (gm_ready) begin
            gm_write_q <= 1'b0;
        end
    end

    assign gm_write = gm_write_q;
    assign gm_col   = gm_col_q;
    assign gm_row   = gm_row_q;
    assign gm_color = gm_color_q;

`ifdef PIXEL_WRITE_ARBITER_CLEAR_EN
    localparam logic [8:0] C_LAST_COL = 9'(COL_NUM - 1);
    localparam logic [7:0] C_LAST_ROW = 8'(ROW_NUM - 1);

    logic       clear_busy_q;
    logic       clear_done_q;
    logic [8:0] clr_col_q;
    logic [7:0] clr_row_q;

    assign w_clear_pend = clear_busy_q;
    assign w_clr_acc    = (state_q == CLEAR) && w_stage_free;
    assign w_clr_last   = (clr_col_q == C_LAST_COL) && (clr_row_q == C_LAST_ROW);
    assign w_clr_col    = clr_col_q;
    assign w_clr_row    = clr_row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            clr_col_q    <= '0;
            clr_row_q    <= '0;
        end else begin
            clear_done_q <= 1'b0;
            if (w_clr_acc && w_clr_last) begin
                clear_busy_q <= 1'b0;
                clear_done_q <= 1'b1;
                clr_col_q    <= '0;
                clr_row_q    <= '0;
            end else begin
                if (clear_req && !clear_busy_q && (state_q != WAIT_INIT)) begin
                    clear_busy_q <= 1'b1;
                end
                if (w_clr_acc) begin
                    if (clr_col_q == C_LAST_COL) begin
                        clr_col_q <= '0;
                        clr_row_q <= clr_row_q + 1'b1;
                    end else begin
                        clr_col_q <= clr_col_q + 1'b1;
                    end
                end
            end
        end
    end

    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
`else
    localparam int unused_dims = COL_NUM + ROW_NUM;
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign w_clear_pend     = 1'b0;
    assign w_clr_acc        = 1'b0;
    assign w_clr_last       = 1'b0;
    assign w_clr_col        = '0;
    assign w_clr_row        = '0;
    assign clear_busy       = 1'b0;
    assign clear_done       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
// ============================================================================
// Module   : tb_pixel_write_arbiter
// Brief    : Directed self-checking bench for pixel_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_write_arbiter;

    logic       clk = 1'b0;
    logic       reset, initialized;
    logic       p_valid, p_lock, p_color, p_ready;
    logic [8:0] p_col;
    logic [7:0] p_row;
    logic       o_valid, o_lock, o_color, o_ready;
    logic [8:0] o_col;
    logic [7:0] o_row;
    logic       clear_req, clear_busy, clear_done;
    logic       gm_ready, gm_write, gm_color;
    logic [8:0] gm_col;
    logic [7:0] gm_row;

    int n_total = 0;
    int n_bad   = 0;

    logic r_p, r_o;
    int   src_q[$];
    int   wr_q[$];
    logic log_wr   = 1'b0;
    logic clr_mode = 1'b0;
    int   n_wr = 0, n_done = 0, n_clr_wr = 0, n_nonzero = 0, n_order = 0, n_p_in_clr = 0;
    int   exp_c = 0, exp_r = 0, last_c = 0, last_r = 0;

    pixel_write_arbiter #(
        .COL_NUM      (320),
        .ROW_NUM      (240),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .initialized (initialized),
        .p_valid     (p_valid),
        .p_lock      (p_lock),
        .p_col       (p_col),
        .p_row       (p_row),
        .p_color     (p_color),
        .p_ready     (p_ready),
        .o_valid     (o_valid),
        .o_lock      (o_lock),
        .o_col       (o_col),
        .o_row       (o_row),
        .o_color     (o_color),
        .o_ready     (o_ready),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .gm_ready    (gm_ready),
        .gm_write    (gm_write),
        .gm_col      (gm_col),
        .gm_row      (gm_row),
        .gm_color    (gm_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: observe settled outputs mid-cycle, then advance past the edge.
    task automatic step();
        #1;
        r_p = p_ready;
        r_o = o_ready;
        if (!reset) begin
            if (r_p) src_q.push_back(1);
            if (r_o) src_q.push_back(2);
            if (gm_write && gm_ready) begin
                n_wr++;
                if (log_wr) wr_q.push_back(int'(gm_col));
                if (clr_mode) begin
                    n_clr_wr++;
                    if (gm_color) n_nonzero++;
                    if (int'(gm_col) != exp_c || int'(gm_row) != exp_r) n_order++;
                    last_c = int'(gm_col);
                    last_r = int'(gm_row);
                    if (exp_c == 319) begin
                        exp_c = 0;
                        exp_r++;
                    end else begin
                        exp_c++;
                    end
                end
            end
            if (clr_mode && r_p) n_p_in_clr++;
            if (clear_done) begin
                n_done++;
                clr_mode = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (r_p) p_col = p_col + 9'd1;
        if (r_o) o_col = o_col + 9'd1;
    endtask

    task automatic first_beat_latency(output int lat);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (r_p) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, cnt, idx, snap, seq_err, n_acc, n_o, n_pp, busy_mid;

        reset = 1'b1; initialized = 1'b0;
        p_valid = 1'b0; p_lock = 1'b0; p_col = '0; p_row = '0; p_color = 1'b0;
        o_valid = 1'b0; o_lock = 1'b0; o_col = '0; o_row = '0; o_color = 1'b0;
        clear_req = 1'b0; gm_ready = 1'b1;
        repeat (3) step();
        check("rst_gm_write", gm_write, 0);
        check("rst_gm_coord", {gm_col, gm_row, gm_color}, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clear_done", clear_done, 0);
        reset = 1'b0;

        // Not initialized: painter request must be held off.
        p_valid = 1'b1; p_col = 9'd100; p_row = 8'd50; p_color = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (r_p || gm_write) cnt++;
        end
        check("wait_init_hold", cnt, 0);
        initialized = 1'b1;
        first_beat_latency(lat);
        p_valid = 1'b0;
        check("first_beat_lat", lat, 2);
        check("first_gm_write", gm_write, 1);
        check("first_gm_pixel", {gm_col, gm_row, gm_color}, {9'd100, 8'd50, 1'b1});
        repeat (3) step();
        check("first_gm_drop", gm_write, 0);

        // Simultaneous requests, painter first, overlay after 4 painter beats.
        src_q.delete();
        p_valid = 1'b1; o_valid = 1'b1; p_col = 9'd0; o_col = 9'd300;
        for (int k = 0; k < 20; k++) begin
            step();
            if (r_o) begin
                o_valid = 1'b0;
                break;
            end
        end
        p_valid = 1'b0;
        repeat (3) step();
        idx = -1;
        foreach (src_q[i]) if (idx < 0 && src_q[i] == 2) idx = i;
        check("prio_painter_first", src_q.size() > 0 ? src_q[0] : 0, 1);
        check("starve_grant_after", idx, 4);
        check("starve_seq_len", src_q.size(), 5);

        // Locked overlay burst with valid gaps while the painter waits.
        src_q.delete();
        o_lock = 1'b1; o_valid = 1'b1; p_valid = 1'b0;
        step();
        p_valid = 1'b1;
        n_o = 0;
        for (int k = 0; k < 40 && n_o < 8; k++) begin
            o_valid = (k % 3) != 2;
            step();
            if (r_o) n_o++;
        end
        o_lock = 1'b0; o_valid = 1'b0;
        repeat (6) step();
        p_valid = 1'b0;
        repeat (3) step();
        idx = -1; n_o = 0; n_pp = 0;
        foreach (src_q[i]) begin
            if (src_q[i] == 2) n_o++;
            if (src_q[i] == 1) begin
                n_pp++;
                if (idx < 0) idx = i;
            end
        end
        check("burst_o_beats", n_o, 8);
        check("burst_first_p_idx", idx, 8);
        check("burst_p_after", n_pp > 0, 1);

        // Output stall in the middle of a locked painter stream.
        src_q.delete(); wr_q.delete(); log_wr = 1'b1;
        p_col = 9'd10; p_lock = 1'b1; p_valid = 1'b1; gm_ready = 1'b1;
        repeat (4) step();
        gm_ready = 1'b0;
        snap = int'(gm_col);
        check("stall_col", snap, 12);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (r_p || !gm_write || int'(gm_col) != snap) cnt++;
        end
        check("stall_hold", cnt, 0);
        gm_ready = 1'b1;
        repeat (4) step();
        p_valid = 1'b0; p_lock = 1'b0;
        repeat (3) step();
        log_wr = 1'b0;
        n_acc = 0;
        foreach (src_q[i]) if (src_q[i] == 1) n_acc++;
        seq_err = 0;
        foreach (wr_q[i]) if (wr_q[i] != 10 + i) seq_err++;
        check("stall_n_accept", n_acc, 7);
        check("stall_n_written", wr_q.size(), 7);
        check("stall_seq_err", seq_err, 0);

`ifdef PIXEL_WRITE_ARBITER_CLEAR_EN
        // Full-screen clear with a second request ignored mid-sweep.
        n_done = 0; n_clr_wr = 0; n_nonzero = 0; n_order = 0; n_p_in_clr = 0;
        exp_c = 0; exp_r = 0; busy_mid = 0;
        clr_mode = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 80000 && clr_mode; k++) begin
            clear_req = (k == 500);
            if (k == 100) p_valid = 1'b1;
            if (k == 500) busy_mid = clear_busy;
            step();
        end
        clear_req = 1'b0; p_valid = 1'b0;
        repeat (4) step();
        check("clr_finished", clr_mode, 0);
        check("clr_writes", n_clr_wr, 76800);
        check("clr_nonzero", n_nonzero, 0);
        check("clr_order_err", n_order, 0);
        check("clr_last_col", last_c, 319);
        check("clr_last_row", last_r, 239);
        check("clr_done_pulses", n_done, 1);
        check("clr_busy_mid", busy_mid, 1);
        check("clr_busy_after", clear_busy, 0);
        check("clr_p_ready", n_p_in_clr, 0);

        // Reset at pixel 1000 of a second clear.
        n_clr_wr = 0; exp_c = 0; exp_r = 0; n_done = 0;
        clr_mode = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 5000 && n_clr_wr < 1000; k++) step();
        check("abort_reached_1000", n_clr_wr, 1000);
        reset = 1'b1; initialized = 1'b0;
        step();
        check("abort_gm_write", gm_write, 0);
        check("abort_busy", clear_busy, 0);
        check("abort_done", clear_done, 0);
        reset = 1'b0; clr_mode = 1'b0;
`else
        // Without the clear feature a request must do nothing.
        n_wr = 0; n_done = 0; cnt = 0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (clear_busy) cnt++;
        end
        check("noclr_busy", cnt, 0);
        check("noclr_writes", n_wr, 0);
        check("noclr_done", n_done, 0);

        // Reset in the middle of a locked painter burst.
        p_lock = 1'b1; p_valid = 1'b1;
        repeat (6) step();
        check("abort_pre_write", gm_write, 1);
        reset = 1'b1; initialized = 1'b0;
        step();
        check("abort_gm_write", gm_write, 0);
        reset = 1'b0; p_lock = 1'b0;
`endif

        // After reset the arbiter must sit in WAIT_INIT again.
        p_valid = 1'b1; p_lock = 1'b0; p_col = 9'd200;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (r_p || gm_write || clear_done) cnt++;
        end
        check("abort_wait_init", cnt, 0);
        check("abort_no_done", n_done, 0);
        initialized = 1'b1;
        first_beat_latency(lat);
        p_valid = 1'b0;
        check("abort_reinit_lat", lat, 2);
        check("abort_reinit_col", gm_col, 200);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
